frost32_mem_access_unit: RTL

- Parametrised load/store engine between the Frost32 pipeline's memory-access stage and a word-wide data bus.
- Accepts one CPU request (address, type, size, write data) and turns it into one or two aligned bus beats with byte enables.
- Merges, shifts and sign- or zero-extends read data.
- Generalises the fixed 32/16/8 access to any power-of-two size up to the bus width, and adds misaligned-access splitting.

---
 rtl/frost32_mem_access_unit_pkg.sv | 43 ++++
 rtl/frost32_mau_lane_align.sv | 50 +++++
 rtl/frost32_mem_access_unit.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/frost32_mem_access_unit_pkg.sv
// Shared types for the Frost32 memory-access unit.
// PkgFrost32Cpu carries the pipeline-wide access type; PkgFrost32Mau carries the unit's own types.
package PkgFrost32Cpu;
  typedef enum logic {
    DiatRead  = 1'b0,
    DiatWrite = 1'b1
  } DataInoutAccessType;
endpackage

package PkgFrost32Mau;
  import PkgFrost32Cpu::*;

  localparam int MAU_SIZE_W        = 2;
  localparam int MAU_NATIVE_ADDR_W = 32;
  localparam int MAU_NATIVE_DATA_W = 32;

  typedef enum logic [1:0] {
    StIdle,
    StBeat0,
    StBeat1,
    StDone
  } MauState;

  typedef enum logic [MAU_SIZE_W-1:0] {
    Dias8L  = 2'd0,
    Dias16L = 2'd1,
    Dias32L = 2'd2,
    Dias64L = 2'd3
  } DataInoutAccessLog2Size;

  // Request as seen by the native 32-bit Frost32 pipeline.
  typedef struct packed {
    logic [MAU_NATIVE_ADDR_W-1:0] addr;
    DataInoutAccessType           access_type;
    DataInoutAccessLog2Size       size;
    logic                         sign_ext;
    logic [MAU_NATIVE_DATA_W-1:0] wdata;
  } MauRequest;

  function automatic logic [7:0] mau_size_bytes(input logic [MAU_SIZE_W-1:0] size);
    return 8'd1 << size;
  endfunction
endpackage

// File: rtl/frost32_mau_lane_align.sv
// Purpose: byte-lane alignment for the memory-access unit (byte enables, store shift, load merge/extend).
// Latency: purely combinational.
// Backpressure: none; inputs are held stable by the owning FSM while the bus stalls.
module frost32_mau_lane_align #(
  parameter  int DATA_WIDTH = 32,
  localparam int NUM_LANES  = DATA_WIDTH / 8,
  localparam int LANE_IDX_W = $clog2(NUM_LANES)
) (
  input  logic [LANE_IDX_W-1:0] offset,
  input  logic [1:0]            size,
  input  logic                  sign_ext,
  input  logic                  beat_sel,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] rdata_lo,
  input  logic [DATA_WIDTH-1:0] rdata_hi,
  output logic [NUM_LANES-1:0]  lane_en,
  output logic [DATA_WIDTH-1:0] lane_wdata,
  output logic [DATA_WIDTH-1:0] rdata_ext
);
  logic [NUM_LANES-1:0]    size_lanes;
  logic [DATA_WIDTH-1:0]   size_bits;
  logic [2*NUM_LANES-1:0]  en_wide;
  logic [2*DATA_WIDTH-1:0] wdata_wide;
  logic [DATA_WIDTH-1:0]   merged;
  logic                    msb;

  always_comb begin
    for (int i = 0; i < NUM_LANES; i++) begin
      size_lanes[i]        = (i < (1 << size));
      size_bits[i*8 +: 8]  = {8{size_lanes[i]}};
    end

    // Two words side by side: the low word is beat 0, the high word carries the spill-over.
    en_wide    = {{NUM_LANES{1'b0}}, size_lanes} << offset;
    wdata_wide = {{DATA_WIDTH{1'b0}}, wdata & size_bits} << {offset, 3'b000};
    lane_en    = beat_sel ? en_wide[2*NUM_LANES-1:NUM_LANES] : en_wide[NUM_LANES-1:0];
    lane_wdata = beat_sel ? wdata_wide[2*DATA_WIDTH-1:DATA_WIDTH] : wdata_wide[DATA_WIDTH-1:0];

    merged = DATA_WIDTH'({rdata_hi, rdata_lo} >> {offset, 3'b000});

    // Enabled lanes are contiguous from lane 0, so the last one holds the access MSB.
    msb = 1'b0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (size_lanes[i]) msb = merged[i*8+7];
    end
    for (int i = 0; i < NUM_LANES; i++) begin
      rdata_ext[i*8 +: 8] = size_lanes[i] ? merged[i*8 +: 8] : {8{sign_ext & msb}};
    end
  end
endmodule

// File: rtl/frost32_mem_access_unit.sv
// Purpose: Frost32 load/store engine; one CPU request becomes one (or, with FROST32_MAU_MISALIGNED_SPLIT_EN, two) aligned bus beats.
// Latency: accept at T, beat at T+1, cpu_done at T+2; +1 per split beat, +1 per mem_stall cycle.
// Backpressure: cpu_ready only in idle; a beat holds all bus fields stable while mem_stall is high.
module frost32_mem_access_unit
  import PkgFrost32Cpu::*;
  import PkgFrost32Mau::*;
#(
  parameter  int DATA_WIDTH = 32,
  parameter  int ADDR_WIDTH = 32,
  localparam int NUM_LANES  = DATA_WIDTH / 8,
  localparam int LANE_IDX_W = $clog2(NUM_LANES),
  localparam int SIZE_W     = MAU_SIZE_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_req,
  output logic                  cpu_ready,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic                  cpu_access_type,
  input  logic [SIZE_W-1:0]     cpu_access_size,
  input  logic                  cpu_sign_ext,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  cpu_done,
  output logic                  cpu_err,
  output logic                  mem_req,
  output logic                  mem_access_type,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [NUM_LANES-1:0]  mem_byte_en,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_stall
);
  typedef struct packed {
    logic [ADDR_WIDTH-1:0]  addr;
    DataInoutAccessType     access_type;
    DataInoutAccessLog2Size size;
    logic                   sign_ext;
    logic [DATA_WIDTH-1:0]  wdata;
  } req_t;

  MauState               state_q, state_d;
  req_t                  req_q;
  logic                  err_q;
  logic [DATA_WIDTH-1:0] rbuf0_q;
  logic [DATA_WIDTH-1:0] rbuf1;
  logic                  accept;
  logic                  size_err;
  logic                  bad_req;
  logic                  beat_sel;
  logic [LANE_IDX_W-1:0] in_off;
  logic [ADDR_WIDTH-1:0] word_addr;
  logic [NUM_LANES-1:0]  lane_en;
  logic [DATA_WIDTH-1:0] lane_wdata;
  logic [DATA_WIDTH-1:0] rdata_ext;

  assign accept    = cpu_req && (state_q == StIdle);
  assign in_off    = cpu_addr[LANE_IDX_W-1:0];
  assign size_err  = int'(cpu_access_size) > LANE_IDX_W;
  assign word_addr = {req_q.addr[ADDR_WIDTH-1:LANE_IDX_W], {LANE_IDX_W{1'b0}}};

`ifdef FROST32_MAU_MISALIGNED_SPLIT_EN
  logic                  in_spill;
  logic                  spill_q;
  logic [DATA_WIDTH-1:0] rbuf1_q;
  logic [ADDR_WIDTH-1:0] next_addr;

  assign in_spill  = ({2'b00, in_off} + (LANE_IDX_W+2)'(mau_size_bytes(cpu_access_size)))
                     > (LANE_IDX_W+2)'(NUM_LANES);
  assign bad_req   = size_err;
  assign next_addr = word_addr + ADDR_WIDTH'(NUM_LANES);
  assign rbuf1     = rbuf1_q;
  assign beat_sel  = (state_q == StBeat1);
`else
  logic [LANE_IDX_W-1:0] size_mask;

  assign size_mask = LANE_IDX_W'(mau_size_bytes(cpu_access_size) - 8'd1);
  assign bad_req   = size_err || ((in_off & size_mask) != '0);
  assign rbuf1     = '0;
  assign beat_sel  = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      req_q   <= '0;
      err_q   <= 1'b0;
      rbuf0_q <= '0;
`ifdef FROST32_MAU_MISALIGNED_SPLIT_EN
      spill_q <= 1'b0;
      rbuf1_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      if (accept) begin
        req_q <= '{addr:        cpu_addr,
                   access_type: DataInoutAccessType'(cpu_access_type),
                   size:        DataInoutAccessLog2Size'(cpu_access_size),
                   sign_ext:    cpu_sign_ext,
                   wdata:       cpu_wdata};
        err_q <= bad_req;
`ifdef FROST32_MAU_MISALIGNED_SPLIT_EN
        spill_q <= in_spill;
`endif
      end
      if ((state_q == StBeat0) && !mem_stall) rbuf0_q <= mem_rdata;
`ifdef FROST32_MAU_MISALIGNED_SPLIT_EN
      if ((state_q == StBeat1) && !mem_stall) rbuf1_q <= mem_rdata;
`endif
    end
  end

  always_comb begin
    state_d         = state_q;
    cpu_ready       = 1'b0;
    cpu_done        = 1'b0;
    cpu_err         = 1'b0;
    cpu_rdata       = '0;
    mem_req         = 1'b0;
    mem_access_type = DiatRead;
    mem_addr        = '0;
    mem_wdata       = '0;
    mem_byte_en     = '0;
    unique case (state_q)
      StIdle: begin
        cpu_ready = 1'b1;
        if (cpu_req) state_d = bad_req ? StDone : StBeat0;
      end
      StBeat0: begin
        mem_req         = 1'b1;
        mem_access_type = req_q.access_type;
        mem_addr        = word_addr;
        mem_byte_en     = lane_en;
        if (req_q.access_type == DiatWrite) mem_wdata = lane_wdata;
`ifdef FROST32_MAU_MISALIGNED_SPLIT_EN
        if (!mem_stall) state_d = spill_q ? StBeat1 : StDone;
`else
        if (!mem_stall) state_d = StDone;
`endif
      end
`ifdef FROST32_MAU_MISALIGNED_SPLIT_EN
      StBeat1: begin
        mem_req         = 1'b1;
        mem_access_type = req_q.access_type;
        mem_addr        = next_addr;
        mem_byte_en     = lane_en;
        if (req_q.access_type == DiatWrite) mem_wdata = lane_wdata;
        if (!mem_stall) state_d = StDone;
      end
`endif
      StDone: begin
        cpu_done = 1'b1;
        cpu_err  = err_q;
        if (!err_q && (req_q.access_type == DiatRead)) cpu_rdata = rdata_ext;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  frost32_mau_lane_align #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_align (
    .offset     (req_q.addr[LANE_IDX_W-1:0]),
    .size       (req_q.size),
    .sign_ext   (req_q.sign_ext),
    .beat_sel   (beat_sel),
    .wdata      (req_q.wdata),
    .rdata_lo   (rbuf0_q),
    .rdata_hi   (rbuf1),
    .lane_en    (lane_en),
    .lane_wdata (lane_wdata),
    .rdata_ext  (rdata_ext)
  );
endmodule
